core_boot_ctrl: RTL and testbench

Boot and run sequencer for the RV32 datapath. It accepts 32-bit instruction words over a valid/ready stream and writes them little-endian, one byte per cycle, into the byte-addressed 4 KiB instruction memory. On command it releases the datapath from reset and gates its clock enable. It supports halt/resume and counts executed cycles, so benches and a host interface no longer hand-poke memory bytes and free-run the clock.

---
 rtl/core_ctrl_pkg.sv | 20 ++
 rtl/sat_counter.sv | 22 ++
 rtl/core_boot_ctrl.sv | 148 ++++++++++++++
 tb/tb_core_boot_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the boot/run sequencer.
// The STEP state exists only when CORE_BOOT_STEP_EN is defined.
package core_ctrl_pkg;

    localparam int IMEM_BYTES     = 4096;
    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_WORDS     = IMEM_BYTES / BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RUN  = 3'd2,
        HALT = 3'd3
`ifdef CORE_BOOT_STEP_EN
        ,
        STEP = 3'd4
`endif
    } core_boot_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset, clear and count enable.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, holding at all-ones once reached.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot and run sequencer: streams 32-bit words into byte-wide instruction
// memory little-endian, then releases and gates the datapath.
// Optional single-step support is built when CORE_BOOT_STEP_EN is defined.
module core_boot_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int IMEM_AW = 12,
    parameter int CYC_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    input  logic               start,
    input  logic               halt_req,
`ifdef CORE_BOOT_STEP_EN
    input  logic               step_req,
`endif
    output logic               im_we,
    output logic [IMEM_AW-1:0] im_addr,
    output logic [7:0]         im_wdata,
    output logic               dp_rst,
    output logic               dp_en,
    output logic               loaded,
    output logic               err,
    output logic [CYC_W-1:0]   cycles,
    output logic [2:0]         state
);

    localparam logic [IMEM_AW-2:0] FULL_CNT = (IMEM_AW-1)'(IMEM_WORDS);

    core_boot_state_t   st;
    logic [31:0]        word_q;
    logic               last_q;
    logic [1:0]         byte_idx;
    logic [1:0]         next_idx;
    logic [IMEM_AW-1:0] base;
    logic [IMEM_AW-2:0] word_cnt;
    logic               full;
    logic               cyc_clr;

    assign full     = (word_cnt == FULL_CNT);
    assign ld_ready = (st == IDLE) && !full;
    assign next_idx = byte_idx + 2'd1;
    assign cyc_clr  = (st == IDLE) && !ld_valid && start && loaded;
    assign state    = st;

    // Latch the accepted word; these hold data only, so they skip reset.
    // NOTE: word_q/last_q are always written on accept before being read, so no reset is needed.
    always_ff @(posedge clk) begin
        if ((st == IDLE) && ld_valid && !full) begin
            word_q <= ld_data;
            last_q <= ld_last;
        end
    end

    // Sequencer FSM with registered memory-port and datapath-control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            dp_rst   <= 1'b1;
            dp_en    <= 1'b0;
            loaded   <= 1'b0;
            err      <= 1'b0;
            base     <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
        end else begin
            case (st)
                IDLE: begin
                    im_we <= 1'b0;
                    if (ld_valid) begin
                        if (full) begin
                            err <= 1'b1;
                        end else begin
                            byte_idx <= 2'd0;
                            im_we    <= 1'b1;
                            im_addr  <= base;
                            im_wdata <= ld_data[7:0];
                            st       <= WR;
                        end
                    end else if (start && loaded) begin
                        dp_rst <= 1'b0;
                        dp_en  <= 1'b1;
                        st     <= RUN;
                    end
                end
                WR: begin
                    if (byte_idx == 2'd3) begin
                        im_we    <= 1'b0;
                        base     <= base + IMEM_AW'(BYTES_PER_WORD);
                        word_cnt <= word_cnt + (IMEM_AW-1)'(1);
                        if (last_q) begin
                            loaded <= 1'b1;
                        end
                        st <= IDLE;
                    end else begin
                        byte_idx <= next_idx;
                        im_addr  <= base + IMEM_AW'(next_idx);
                        im_wdata <= word_q[{next_idx, 3'b000} +: 8];
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        dp_en <= 1'b0;
                        st    <= HALT;
                    end
                end
                HALT: begin
                    if (start) begin
                        dp_en <= 1'b1;
                        st    <= RUN;
`ifdef CORE_BOOT_STEP_EN
                    end else if (step_req) begin
                        dp_en <= 1'b1;
                        st    <= STEP;
`endif
                    end
                end
`ifdef CORE_BOOT_STEP_EN
                STEP: begin
                    dp_en <= 1'b0;
                    st    <= HALT;
                end
`endif
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CYC_W)
    ) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (cyc_clr),
        .en    (dp_en),
        .count (cycles)
    );

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Self-checking bench for core_boot_ctrl: random words and run lengths are
// checked against a transaction-level model of the load stream and run phases.
`timescale 1ns/1ps
module tb_core_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst, ld_valid, ld_last, start, halt_req;
    logic [31:0] ld_data;
`ifdef CORE_BOOT_STEP_EN
    logic        step_req;
`endif
    logic        ld_ready, im_we, dp_rst, dp_en, loaded, err;
    logic [11:0] im_addr;
    logic [7:0]  im_wdata;
    logic [31:0] cycles;
    logic [2:0]  state;

    core_boot_ctrl #(.IMEM_AW(12), .CYC_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .start    (start),
        .halt_req (halt_req),
`ifdef CORE_BOOT_STEP_EN
        .step_req (step_req),
`endif
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .dp_rst   (dp_rst),
        .dp_en    (dp_en),
        .loaded   (loaded),
        .err      (err),
        .cycles   (cycles),
        .state    (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_RUN, P_HALT, P_STEP} phase_t;
    typedef struct {
        int         when;
        logic [11:0] addr;
        logic [7:0]  data;
    } byte_wr_t;

    byte_wr_t    exp_q[$];
    logic [7:0]  ref_mem [4096];
    logic [7:0]  shadow  [4096];
    int          cyc_no = 0;
    phase_t      m_phase = P_IDLE;
    int          m_free = 0, m_base = 0, m_words = 0;
    bit          m_loaded = 0, m_err = 0, m_released = 0, m_pend = 0, m_pend_last = 0;
    longint      m_cycles = 0;
    int          wr_bad = 0, hs_bad = 0, en_bad = 0, drst_bad = 0, cyc_bad = 0, st_bad = 0, flag_bad = 0;
    int          en_cnt = 0, last_wr_addr = -1, gap_bad = 0;

    function automatic void model_reset();
        exp_q.delete();
        m_phase    = P_IDLE;
        m_free     = cyc_no;
        m_base     = 0;
        m_words    = 0;
        m_loaded   = 0;
        m_err      = 0;
        m_released = 0;
        m_pend     = 0;
        m_cycles   = 0;
    endfunction

    // Compare every output of the cycle just entered with the model.
    task automatic sample();
        byte_wr_t   e;
        bit         exp_en;
        logic [2:0] exp_st;
        if (exp_q.size() > 0 && exp_q[0].when == cyc_no) begin
            e = exp_q.pop_front();
            if (im_we !== 1'b1 || im_addr !== e.addr || im_wdata !== e.data) wr_bad++;
            ref_mem[e.addr] = e.data;
        end else if (im_we !== 1'b0) begin
            wr_bad++;
        end
        if (im_we === 1'b1) begin
            shadow[im_addr] = im_wdata;
            last_wr_addr    = int'(im_addr);
        end
        exp_en = (m_phase == P_RUN) || (m_phase == P_STEP);
        if (dp_en !== exp_en) en_bad++;
        if (dp_en === 1'b1) en_cnt++;
        if (dp_rst !== !m_released) drst_bad++;
        if (cycles !== m_cycles[31:0]) cyc_bad++;
        case (m_phase)
            P_IDLE:  exp_st = (cyc_no < m_free) ? 3'd1 : 3'd0;
            P_RUN:   exp_st = 3'd2;
            P_HALT:  exp_st = 3'd3;
            default: exp_st = 3'd4;
        endcase
        if (state !== exp_st) st_bad++;
        if (loaded !== m_loaded || err !== m_err) flag_bad++;
    endtask

    // Advance one clock: predict the edge from the model, then sample.
    task automatic cyc(output bit acc);
        bit idle_free, ready_m, rst_now;
        rst_now   = rst;
        idle_free = (m_phase == P_IDLE) && (cyc_no >= m_free);
        ready_m   = idle_free && (m_words < 1024);
        if (!rst_now && ld_ready !== ready_m) hs_bad++;
        acc = !rst_now && ready_m && ld_valid;
        if (!rst_now) begin
            if (m_phase == P_RUN || m_phase == P_STEP) m_cycles++;
            if (acc) begin
                for (int k = 0; k < 4; k++)
                    exp_q.push_back('{cyc_no + 1 + k, 12'(m_base + k), 8'(ld_data >> (8 * k))});
                m_base      = (m_base + 4) % 4096;
                m_free      = cyc_no + 5;
                m_pend      = 1;
                m_pend_last = ld_last;
            end else if (idle_free && ld_valid) begin
                m_err = 1;
            end else if (idle_free && start && m_loaded) begin
                m_phase    = P_RUN;
                m_released = 1;
                m_cycles   = 0;
            end else if (m_phase == P_RUN && halt_req) begin
                m_phase = P_HALT;
            end else if (m_phase == P_HALT && start) begin
                m_phase = P_RUN;
`ifdef CORE_BOOT_STEP_EN
            end else if (m_phase == P_HALT && step_req) begin
                m_phase = P_STEP;
            end else if (m_phase == P_STEP) begin
                m_phase = P_HALT;
`endif
            end
        end
        @(posedge clk);
        #1;
        cyc_no++;
        if (rst_now) begin
            model_reset();
        end else if (m_pend && cyc_no == m_free) begin
            m_pend = 0;
            m_words++;
            if (m_pend_last) m_loaded = 1;
        end
        sample();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(acc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    // Present one word (ld_valid left high) and wait for its handshake.
    task automatic load_word(input logic [31:0] w, input bit last, inout int prev_acc);
        bit acc;
        int waited;
        ld_valid = 1'b1;
        ld_data  = w;
        ld_last  = last;
        acc      = 1'b0;
        waited   = 0;
        while (!acc && waited < 20) begin
            cyc(acc);
            waited++;
        end
        if (!acc) begin
            check("accept_timeout", 64'(waited), 64'd0);
        end else begin
            if (prev_acc >= 0 && cyc_no - prev_acc != 5) gap_bad++;
            prev_acc = cyc_no;
        end
    endtask

    task automatic load_burst(input int n, input bit rand_last);
        int  prev;
        bit  lst;
        prev = -1;
        for (int i = 0; i < n; i++) begin
            lst = (i == n - 1) ? 1'b1 : (rand_last ? 1'($urandom_range(0, 1)) : 1'b0);
            load_word($urandom, lst, prev);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        idle(5);
    endtask

    // Fold the per-cycle error counters into named comparisons.
    task automatic settle(input string tag);
        check({tag, "_bytes"},   64'(wr_bad),   64'd0);
        check({tag, "_ready"},   64'(hs_bad),   64'd0);
        check({tag, "_dp_en"},   64'(en_bad),   64'd0);
        check({tag, "_dp_rst"},  64'(drst_bad), 64'd0);
        check({tag, "_cycles"},  64'(cyc_bad),  64'd0);
        check({tag, "_state"},   64'(st_bad),   64'd0);
        check({tag, "_flags"},   64'(flag_bad), 64'd0);
        check({tag, "_gaps"},    64'(gap_bad),  64'd0);
        wr_bad = 0; hs_bad = 0; en_bad = 0; drst_bad = 0;
        cyc_bad = 0; st_bad = 0; flag_bad = 0; gap_bad = 0;
    endtask

    task automatic run_for(input int len, input string tag);
        int  en0;
        bit  acc;
        longint c0;
        en0      = en_cnt;
        c0       = m_cycles;
        start    = 1'b1;
        cyc(acc);
        start    = 1'b0;
        check({tag, "_dp_en_on"},  64'(dp_en),  64'd1);
        check({tag, "_dp_rst_off"}, 64'(dp_rst), 64'd0);
        idle(len - 1);
        halt_req = 1'b1;
        cyc(acc);
        halt_req = 1'b0;
        check({tag, "_en_count"}, 64'(en_cnt - en0), 64'(len));
        check({tag, "_total"},    64'(cycles),       64'(c0 + len));
    endtask

    initial begin : stim
        int          prev, mism, r1, r2;
        logic [31:0] w;
        bit          acc;
        rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        start = 1'b0; halt_req = 1'b0;
`ifdef CORE_BOOT_STEP_EN
        step_req = 1'b0;
`endif
        // Reset values.
        idle(1);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        check("rst_im_we",    64'(im_we),    64'd0);
        check("rst_im_addr",  64'(im_addr),  64'd0);
        check("rst_im_wdata", 64'(im_wdata), 64'd0);
        check("rst_dp_rst",   64'(dp_rst),   64'd1);
        check("rst_dp_en",    64'(dp_en),    64'd0);
        check("rst_loaded",   64'(loaded),   64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_cycles",   64'(cycles),   64'd0);
        check("rst_state",    64'(state),    64'd0);
        rst = 1'b0;

        // Single known instruction, little-endian bytes.
        prev = -1;
        load_word(32'h0050_0613, 1'b1, prev);
        ld_valid = 1'b0;
        idle(5);
        check("w0_b0", 64'(shadow[0]), 64'h13);
        check("w0_b1", 64'(shadow[1]), 64'h06);
        check("w0_b2", 64'(shadow[2]), 64'h50);
        check("w0_b3", 64'(shadow[3]), 64'h00);
        check("w0_loaded", 64'(loaded), 64'd1);
        settle("single");

        // Seven back-to-back words from address 0.
        do_reset();
        load_burst(7, 1'b1);
        check("burst_last_addr", 64'(last_wr_addr), 64'd27);
        settle("burst7");

        // ld_valid together with start in IDLE: the load wins.
        start = 1'b1;
        prev  = -1;
        load_word($urandom, 1'b0, prev);
        start    = 1'b0;
        ld_valid = 1'b0;
        check("prio_dp_en", 64'(dp_en), 64'd0);
        idle(5);
        settle("prio");

        // Run/halt/resume with fixed then random lengths.
        run_for(10, "run10");
        check("run10_cycles", 64'(cycles), 64'd10);
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = $urandom;
            idle(1);
        end
        ld_valid = 1'b0;
        run_for(5, "run5");
        check("run5_cycles", 64'(cycles), 64'd15);
        r1 = $urandom_range(1, 25);
        r2 = $urandom_range(1, 25);
        run_for(r1, "runr1");
        idle($urandom_range(0, 4));
        run_for(r2, "runr2");
        check("runr_cycles", 64'(cycles), 64'(15 + r1 + r2));
        settle("run");

        // Reset while byte 2 of a word is on the bus.
        do_reset();
        prev = -1;
        load_word($urandom, 1'b1, prev);
        ld_valid = 1'b0;
        idle(2);
        check("abort_byte2_addr", 64'(im_addr), 64'd2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("abort_state",  64'(state),  64'd0);
        check("abort_im_we",  64'(im_we),  64'd0);
        check("abort_loaded", 64'(loaded), 64'd0);
        w    = $urandom;
        prev = -1;
        load_word(w, 1'b1, prev);
        ld_valid = 1'b0;
        idle(5);
        check("reload_word", 64'({shadow[3], shadow[2], shadow[1], shadow[0]}), 64'(w));
        check("reload_loaded", 64'(loaded), 64'd1);
        settle("abort");

        // Fill all 1024 words, then overflow.
        do_reset();
        load_burst(1024, 1'b1);
        check("full_ready", 64'(ld_ready), 64'd0);
        ld_valid = 1'b1;
        ld_data  = $urandom;
        idle(4);
        ld_valid = 1'b0;
        check("full_err", 64'(err), 64'd1);
        idle(2);
        mism = 0;
        for (int a = 0; a < 4096; a++)
            if (shadow[a] !== ref_mem[a]) mism++;
        check("full_image", 64'(mism), 64'd0);
        settle("full");
        do_reset();
        check("clr_err",    64'(err),    64'd0);
        check("clr_loaded", 64'(loaded), 64'd0);

`ifdef CORE_BOOT_STEP_EN
        // Single-step from HALT.
        prev = -1;
        load_word($urandom, 1'b1, prev);
        ld_valid = 1'b0;
        idle(5);
        run_for(3, "prestep");
        begin
            int en0;
            en0 = en_cnt;
            for (int i = 0; i < 3; i++) begin
                step_req = 1'b1;
                idle(1);
                step_req = 1'b0;
                idle(2);
            end
            check("step_pulses", 64'(en_cnt - en0), 64'd3);
            check("step_cycles", 64'(cycles), 64'd6);
            en0 = en_cnt;
            step_req = 1'b1;
            idle(6);
            step_req = 1'b0;
            idle(1);
            check("step_held", 64'(en_cnt - en0), 64'd3);
            start    = 1'b1;
            step_req = 1'b1;
            idle(1);
            start    = 1'b0;
            step_req = 1'b0;
            check("step_start_run", 64'(state), 64'd2);
            halt_req = 1'b1;
            idle(1);
            halt_req = 1'b0;
        end
        settle("step");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case stimulus stalls.
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
